// File: rtl/rom_bus_arbiter_if.sv
// rom_bus_arbiter_if: requester, cache-control and external ROM bus signals of the arbiter.
interface rom_bus_arbiter_if;
  logic        p0_req_in, p1_req_in;
  logic [15:0] p0_addr_in, p1_addr_in;
  logic        p0_gnt_out, p1_gnt_out;
  logic        p0_done_out, p1_done_out;
  logic [7:0]  data_out;
  logic        invalidate_in;
  logic [7:0]  rom_addr_out;
  logic        rom_latch_out;
  logic [7:0]  rom_data_in;
  logic        busy_out;
  modport slave (
    input  p0_req_in, p1_req_in, p0_addr_in, p1_addr_in, invalidate_in, rom_data_in,
    output p0_gnt_out, p1_gnt_out, p0_done_out, p1_done_out, data_out, rom_addr_out, rom_latch_out, busy_out
  );
  modport master (
    output p0_req_in, p1_req_in, p0_addr_in, p1_addr_in, invalidate_in, rom_data_in,
    input  p0_gnt_out, p1_gnt_out, p0_done_out, p1_done_out, data_out, rom_addr_out, rom_latch_out, busy_out
  );
endinterface

// File: rtl/rom_bus_arbiter.sv
// rom_bus_arbiter: round-robin two-port reader of a multiplexed-address ROM with a cached high byte.
module rom_bus_arbiter #(
  parameter int PERIOD_NS = 10,
  parameter int SETUP_NS  = 50,
  parameter int HOLD_NS   = 5,
  parameter int DELAY_NS  = 250
) (
  input logic clk_in,
  input logic rst_in,
  rom_bus_arbiter_if.slave bus
);
  localparam int SETUP_CYC = (SETUP_NS + PERIOD_NS - 1) / PERIOD_NS;
  localparam int HOLD_RAW  = (HOLD_NS + PERIOD_NS - 1) / PERIOD_NS;
  localparam int HOLD_CYC  = HOLD_RAW < 1 ? 1 : HOLD_RAW;
  localparam int DELAY_CYC = (DELAY_NS + PERIOD_NS - 1) / PERIOD_NS;
  localparam int MAX_A     = SETUP_CYC > HOLD_CYC ? SETUP_CYC : HOLD_CYC;
  localparam int MAX_CYC   = MAX_A > DELAY_CYC ? MAX_A : DELAY_CYC;
  localparam int CW        = $clog2(MAX_CYC + 2);
  typedef enum logic [2:0] {IDLE, SETUP_HI, HOLD_HI, DRIVE_LO, WAIT_DATA, DONE} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [15:0] addr_q, addr_d, waddr;
  logic [7:0] hc_q, hc_d, data_q, data_d, ra_q, ra_d;
  logic id_q, id_d, pri_q, pri_d, hv_q, hv_d, g0_q, g0_d, g1_q, g1_d;
  logic d0_q, d0_d, d1_q, d1_d, lat_q, lat_d, busy_q, busy_d, win;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    addr_d  = addr_q;
    id_d    = id_q;
    pri_d   = pri_q;
    hc_d    = hc_q;
    hv_d    = hv_q;
    data_d  = data_q;
    ra_d    = ra_q;
    lat_d   = lat_q;
    g0_d    = 1'b0;
    g1_d    = 1'b0;
    d0_d    = 1'b0;
    d1_d    = 1'b0;
    win     = (bus.p0_req_in & bus.p1_req_in) ? pri_q : bus.p1_req_in;
    waddr   = win ? bus.p1_addr_in : bus.p0_addr_in;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (bus.p0_req_in | bus.p1_req_in) begin
          id_d   = win;
          addr_d = waddr;
          pri_d  = ~win;
          g0_d   = ~win;
          g1_d   = win;
          if (hv_q && waddr[15:8] == hc_q) state_d = DRIVE_LO;
          else begin
            ra_d    = waddr[15:8];
            state_d = SETUP_HI;
          end
        end
      end
      SETUP_HI: if (int'(cnt_q) + 1 >= SETUP_CYC) begin
        lat_d   = 1'b1;
        cnt_d   = '0;
        state_d = HOLD_HI;
      end
      HOLD_HI: if (int'(cnt_q) + 1 >= HOLD_CYC) begin
        lat_d   = 1'b0;
        hc_d    = addr_q[15:8];
        hv_d    = 1'b1;
        cnt_d   = '0;
        state_d = DRIVE_LO;
      end
      DRIVE_LO: begin
        ra_d    = addr_q[7:0];
        cnt_d   = '0;
        state_d = WAIT_DATA;
      end
      // one extra sample cycle so data is taken a full DELAY_CYC after the low byte settles
      WAIT_DATA: if (cnt_q == CW'(DELAY_CYC)) begin
        data_d  = bus.rom_data_in;
        d0_d    = ~id_q;
        d1_d    = id_q;
        cnt_d   = '0;
        state_d = DONE;
      end
      DONE: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (bus.invalidate_in) hv_d = 1'b0;
    busy_d = state_d != IDLE;
  end
  always_ff @(posedge clk_in or posedge rst_in)
    if (rst_in) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      id_q    <= 1'b0;
      pri_q   <= 1'b0;
      hc_q    <= '0;
      hv_q    <= 1'b0;
      data_q  <= '0;
      ra_q    <= '0;
      lat_q   <= 1'b0;
      g0_q    <= 1'b0;
      g1_q    <= 1'b0;
      d0_q    <= 1'b0;
      d1_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      id_q    <= id_d;
      pri_q   <= pri_d;
      hc_q    <= hc_d;
      hv_q    <= hv_d;
      data_q  <= data_d;
      ra_q    <= ra_d;
      lat_q   <= lat_d;
      g0_q    <= g0_d;
      g1_q    <= g1_d;
      d0_q    <= d0_d;
      d1_q    <= d1_d;
      busy_q  <= busy_d;
    end
  assign bus.p0_gnt_out    = g0_q;
  assign bus.p1_gnt_out    = g1_q;
  assign bus.p0_done_out   = d0_q;
  assign bus.p1_done_out   = d1_q;
  assign bus.data_out      = data_q;
  assign bus.rom_addr_out  = ra_q;
  assign bus.rom_latch_out = lat_q;
  assign bus.busy_out      = busy_q;
endmodule

// File: tb/tb_rom_bus_arbiter.sv
// tb_rom_bus_arbiter: scoreboard bench with a latched-high-byte ROM model and bus timing monitor.
module tb_rom_bus_arbiter;
  localparam int LAT_MISS = 33;
  localparam int LAT_HIT = 27;
  localparam int SETUP_CYC = 5;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  int rises = 0;
  int stable = 0;
  logic lprev = 1'b0;
  logic [7:0] aprev = '0;
  logic [7:0] rom_hi = '0;
  logic [7:0] exp0[$];
  logic [7:0] exp1[$];
  int order[$];
  logic mhv = 1'b0;
  logic [7:0] mhc = '0;
  logic [7:0] his[3] = '{8'h12, 8'h34, 8'hA0};
  rom_bus_arbiter_if bus();
  rom_bus_arbiter dut (.clk_in(clk), .rst_in(rst), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(posedge clk) if (bus.rom_latch_out) rom_hi <= bus.rom_addr_out;
  function automatic logic [7:0] romf(input logic [15:0] a);
    logic [7:0] h;
    h = a[15:8];
    return a == 16'h1234 ? 8'hAB : (((h << 1) + h + a[7:0]) ^ 8'h3C);
  endfunction
  assign bus.rom_data_in = romf({rom_hi, bus.rom_addr_out});
  always @(negedge clk) begin
    logic [7:0] e;
    if (rst) begin
      lprev = 1'b0;
      aprev = '0;
      stable = 0;
    end else begin
      stable = (bus.rom_addr_out === aprev) ? stable + 1 : 0;
      if (bus.rom_latch_out && !lprev) begin
        rises++;
        n_cmp++;
        if (stable < SETUP_CYC) begin n_fail++; $display("FAIL latch_setup bus stable %0d cycles, required >= %0d", stable, SETUP_CYC); end
      end
      if (lprev) begin
        n_cmp++;
        if (bus.rom_addr_out !== aprev) begin n_fail++; $display("FAIL latch_hold bus %h, required %h", bus.rom_addr_out, aprev); end
      end
      if (bus.p0_done_out) begin
        n_cmp++;
        if (exp0.size() == 0) begin n_fail++; $display("FAIL p0_spurious_done got done, required none"); end
        else begin
          e = exp0.pop_front();
          if (bus.data_out !== e) begin n_fail++; $display("FAIL p0_data got %h, required %h", bus.data_out, e); end
        end
      end
      if (bus.p1_done_out) begin
        n_cmp++;
        if (exp1.size() == 0) begin n_fail++; $display("FAIL p1_spurious_done got done, required none"); end
        else begin
          e = exp1.pop_front();
          if (bus.data_out !== e) begin n_fail++; $display("FAIL p1_data got %h, required %h", bus.data_out, e); end
        end
      end
      if (bus.p0_gnt_out && bus.p1_gnt_out) begin n_cmp++; n_fail++; $display("FAIL dual_grant got both grants, required one"); end
      lprev = bus.rom_latch_out;
      aprev = bus.rom_addr_out;
    end
  end
  task automatic set_req(input bit p, input logic v);
    if (p) bus.p1_req_in = v;
    else bus.p0_req_in = v;
  endtask
  task automatic issue(input bit p, input logic [15:0] a);
    int g, r0;
    bit hit, ok;
    @(negedge clk);
    set_req(p, 1'b1);
    if (p) begin bus.p1_addr_in = a; exp1.push_back(romf(a)); end
    else begin bus.p0_addr_in = a; exp0.push_back(romf(a)); end
    ok = 0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if ((p ? bus.p1_gnt_out : bus.p0_gnt_out) === 1'b1) begin ok = 1; break; end
    end
    n_cmp++;
    if (!ok) begin
      n_fail++;
      $display("FAIL grant_timeout p%0d got no grant, required one within 200 cycles", p);
      set_req(p, 1'b0);
      return;
    end
    g = cyc;
    r0 = rises;
    order.push_back(int'(p));
    hit = mhv && a[15:8] == mhc;
    mhv = 1'b1;
    mhc = a[15:8];
    ok = 0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if ((p ? bus.p1_done_out : bus.p0_done_out) === 1'b1) begin ok = 1; break; end
    end
    set_req(p, 1'b0);
    n_cmp++;
    if (!ok) begin n_fail++; $display("FAIL done_timeout p%0d addr %h got no done, required one", p, a); return; end
    n_cmp++;
    if (cyc - g != (hit ? LAT_HIT : LAT_MISS))
      begin n_fail++; $display("FAIL latency p%0d addr %h got %0d, required %0d", p, a, cyc - g, hit ? LAT_HIT : LAT_MISS); end
    n_cmp++;
    if (rises - r0 != (hit ? 0 : 1))
      begin n_fail++; $display("FAIL latch_pulses p%0d addr %h got %0d, required %0d", p, a, rises - r0, hit ? 0 : 1); end
  endtask
  task automatic pulse_inval();
    bus.invalidate_in = 1'b1;
    mhv = 1'b0;
    @(negedge clk);
    bus.invalidate_in = 1'b0;
  endtask
  task automatic do_reset();
    rst = 1'b1;
    bus.p0_req_in = 1'b0;
    bus.p1_req_in = 1'b0;
    mhv = 1'b0;
    exp0.delete();
    exp1.delete();
    order.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask
  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_cmp++; if (bus.busy_out !== 1'b0) begin n_fail++; $display("FAIL rst_busy got %b, required 0", bus.busy_out); end
    n_cmp++; if (bus.rom_latch_out !== 1'b0) begin n_fail++; $display("FAIL rst_latch got %b, required 0", bus.rom_latch_out); end
    n_cmp++; if (bus.rom_addr_out !== 8'h00) begin n_fail++; $display("FAIL rst_addr got %h, required 00", bus.rom_addr_out); end
    n_cmp++; if (bus.data_out !== 8'h00) begin n_fail++; $display("FAIL rst_data got %h, required 00", bus.data_out); end
    n_cmp++;
    if ({bus.p0_gnt_out, bus.p1_gnt_out, bus.p0_done_out, bus.p1_done_out} !== 4'b0000)
      begin n_fail++; $display("FAIL rst_pulses got %b, required 0000", {bus.p0_gnt_out, bus.p1_gnt_out, bus.p0_done_out, bus.p1_done_out}); end
    rst = 1'b0;
  endtask
  task automatic test_single_miss();
    issue(1'b0, 16'h1234);
    n_cmp++; if (bus.rom_addr_out !== 8'h34) begin n_fail++; $display("FAIL miss_lo_addr got %h, required 34", bus.rom_addr_out); end
    n_cmp++; if (bus.data_out !== 8'hAB) begin n_fail++; $display("FAIL miss_data got %h, required ab", bus.data_out); end
  endtask
  task automatic test_cache_hit();
    issue(1'b1, 16'h12FF);
  endtask
  task automatic test_invalidate();
    issue(1'b0, 16'h12AA);
    @(negedge clk);
    pulse_inval();
    issue(1'b1, 16'h1200);
  endtask
  task automatic test_inval_during_hold();
    bit seen;
    seen = 0;
    fork
      issue(1'b0, 16'h5678);
      begin
        for (int n = 0; n < 60; n++) begin
          @(negedge clk);
          if (bus.rom_latch_out) begin seen = 1; break; end
        end
        if (seen) pulse_inval();
      end
    join
    n_cmp++; if (!seen) begin n_fail++; $display("FAIL hold_window got no latch pulse, required one"); end
    issue(1'b0, 16'h5601);
  endtask
  task automatic test_contention();
    do_reset();
    fork
      begin issue(1'b0, 16'h3401); issue(1'b0, 16'hA002); end
      begin issue(1'b1, 16'h3403); issue(1'b1, 16'h1204); end
    join
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (order.size() <= i || order[i] != i % 2)
        begin n_fail++; $display("FAIL rr_order slot %0d got %0d, required %0d", i, order.size() > i ? order[i] : -1, i % 2); end
    end
  endtask
  task automatic test_reset_midop();
    bit ok;
    ok = 0;
    @(negedge clk);
    bus.p0_addr_in = 16'h1234;
    bus.p0_req_in = 1'b1;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (bus.p0_gnt_out) begin ok = 1; break; end
    end
    n_cmp++; if (!ok) begin n_fail++; $display("FAIL midop_grant got no grant, required one"); end
    repeat (20) @(negedge clk);
    n_cmp++; if (bus.busy_out !== 1'b1) begin n_fail++; $display("FAIL midop_busy got %b, required 1", bus.busy_out); end
    rst = 1'b1;
    #1;
    n_cmp++; if (bus.busy_out !== 1'b0) begin n_fail++; $display("FAIL async_busy got %b, required 0", bus.busy_out); end
    n_cmp++; if (bus.rom_latch_out !== 1'b0) begin n_fail++; $display("FAIL async_latch got %b, required 0", bus.rom_latch_out); end
    n_cmp++; if (bus.p0_done_out !== 1'b0) begin n_fail++; $display("FAIL async_done got %b, required 0", bus.p0_done_out); end
    bus.p0_req_in = 1'b0;
    mhv = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    n_cmp++; if (bus.busy_out !== 1'b0) begin n_fail++; $display("FAIL post_rst_idle got busy %b, required 0", bus.busy_out); end
    issue(1'b0, 16'h1234);
  endtask
  task automatic test_sweep();
    fork
      for (int k = 0; k < 10; k++) begin
        repeat ($urandom_range(0, 5)) @(negedge clk);
        issue(1'b0, {his[$urandom_range(0, 2)], 8'($urandom)});
      end
      for (int k = 0; k < 10; k++) begin
        repeat ($urandom_range(0, 5)) @(negedge clk);
        issue(1'b1, {his[$urandom_range(0, 2)], 8'($urandom)});
      end
    join
    repeat (3) @(negedge clk);
    n_cmp++;
    if (exp0.size() + exp1.size() != 0)
      begin n_fail++; $display("FAIL sweep_leftover got %0d outstanding, required 0", exp0.size() + exp1.size()); end
  endtask
  initial begin
    bus.p0_req_in = 1'b0;
    bus.p1_req_in = 1'b0;
    bus.p0_addr_in = '0;
    bus.p1_addr_in = '0;
    bus.invalidate_in = 1'b0;
    test_reset();
    test_single_miss();
    test_cache_hit();
    test_invalidate();
    test_inval_during_hold();
    test_contention();
    test_reset_midop();
    test_sweep();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL watchdog simulation exceeded 500000 ns, required completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/rom_bus_arbiter.md
ROM_BUS_ARBITER -- requirements
Module: rom_bus_arbiter

Interface
REQ-001 SHALL have parameter PERIOD_NS, 10, clock period in ns.
REQ-002 SHALL have parameter SETUP_NS, 50, address-to-latch-rise setup; SETUP_CYC = ceil(SETUP_NS/PERIOD_NS), default 5.
REQ-003 SHALL have parameter HOLD_NS, 5, latch-high width; HOLD_CYC = max(1, ceil(HOLD_NS/PERIOD_NS)), default 1.
REQ-004 SHALL have parameter DELAY_NS, 250, ROM output delay; DELAY_CYC = ceil(DELAY_NS/PERIOD_NS), default 25.
REQ-005 SHALL use one clock and an asynchronous, active-high reset: clk_in  input  1  clock; rst_in  input  1  async active-high reset.
REQ-006 SHALL have ports p0_req_in / p1_req_in  input  1 each  level read request.
REQ-007 SHALL have ports p0_addr_in / p1_addr_in  input  16 each  byte address, held stable while req high and ungranted.
REQ-008 SHALL have ports p0_gnt_out / p1_gnt_out  output  1 each  one-cycle grant pulse.
REQ-009 SHALL have ports p0_done_out / p1_done_out  output  1 each  one-cycle data-valid pulse.
REQ-010 SHALL have port data_out  output  8  read byte, valid with any done pulse, held until next done.
REQ-011 SHALL have port invalidate_in  input  1  clears the high-address cache (cartridge swap).
REQ-012 SHALL have ports rom_addr_out  output  8  shared external address bus; rom_latch_out  output  1  high-byte latch enable; rom_data_in  input  8  ROM data bus.
REQ-013 SHALL have port busy_out  output  1  high in every state except IDLE.

Function
REQ-014 SHALL implement states IDLE, SETUP_HI, HOLD_HI, DRIVE_LO, WAIT_DATA, DONE; all outputs registered.
REQ-015 IDLE with any req high (grant cycle): SHALL pulse the winner's gnt_out, capture winner id and its addr; exactly one grant per transaction.
REQ-016 Arbitration SHALL be round-robin: one requester -> it wins; both -> the port not granted last wins; after reset port 0 has priority.
REQ-017 Grant cycle, cache hit (hi_valid=1 and addr[15:8]==hi_cache): SHALL go to DRIVE_LO, skipping the high-latch sequence.
REQ-018 Grant cycle, miss: SHALL drive rom_addr_out<=addr[15:8] and enter SETUP_HI with counter cleared.
REQ-019 SETUP_HI SHALL last SETUP_CYC cycles, then assert rom_latch_out and enter HOLD_HI.
REQ-020 HOLD_HI SHALL hold rom_latch_out high HOLD_CYC cycles, then deassert it, set hi_cache<=addr[15:8], hi_valid<=1, enter DRIVE_LO.
REQ-021 rom_addr_out SHALL not change while rom_latch_out is high or in the cycle it falls.
REQ-022 DRIVE_LO SHALL drive rom_addr_out<=addr[7:0] and enter WAIT_DATA.
REQ-023 WAIT_DATA SHALL last DELAY_CYC cycles, then register rom_data_in into data_out, assert the winner's done_out, enter DONE.
REQ-024 DONE SHALL last one cycle with done high, grant nothing, then go to IDLE; requesters drop req on the cycle after done.
REQ-025 Latency grant->done SHALL be SETUP_CYC+HOLD_CYC+DELAY_CYC+2 cycles on miss (33 default) and DELAY_CYC+2 on hit (27 default).
REQ-026 A req rising while the other port's transaction runs SHALL wait, addr held, and be served from the next IDLE.
REQ-027 invalidate_in SHALL clear hi_valid the next edge in any state; if coincident with the HOLD_HI cache update, invalidate wins; an in-flight transaction completes normally.
REQ-028 Counter SHALL be sized for max(SETUP_CYC, HOLD_CYC, DELAY_CYC) and never wrap within a state.

Reset
REQ-029 rst_in high SHALL immediately force state IDLE, all gnt/done outputs 0, data_out 0, rom_addr_out 0, rom_latch_out 0, busy_out 0, hi_valid 0, round-robin pointer to port 0.
REQ-030 Reset mid-transaction SHALL abort it with no done pulse; requesters must re-request after reset.

Verification
REQ-031 Single miss: p0 req addr 0x1234, ROM model returns 0xAB -> p0_gnt, latch pulse 1 cycle with bus 0x12 stable 5 cycles before, bus 0x34, p0_done + data_out 0xAB 33 cycles after grant.
REQ-032 Cache hit: then p1 req 0x12FF -> no latch pulse, p1_done 27 cycles after grant, correct byte.
REQ-033 Contention: both req from reset -> p0 served first, p1 next; both held high again -> p1 is not starved, order alternates p0,p1,p0,p1.
REQ-034 Invalidate: after 0x12xx access, pulse invalidate_in, request 0x1200 -> full latch sequence, 33-cycle latency.
REQ-035 Reset mid-op: assert rst_in in WAIT_DATA -> latch 0, busy 0, no done; post-reset 0x1234 request takes miss path.
REQ-036 Sweep: random addresses from both ports with random req timing vs. ROM model -> every granted request gets exactly one done with correct data; latch/addr timing checker never fires.
